// File: rtl/inf_pkg.sv
// inf_pkg: shared definitions for the NEC infrared transmitter/receiver pair.
//   - NEC default timings in 50 MHz clock cycles
//   - transmitter state enumeration
//   - is_burst(): which states drive the carrier (baseband low)
package inf_pkg;

  localparam int NEC_T_LEAD_LO    = 450000;   // 9 ms leader burst
  localparam int NEC_T_LEAD_HI    = 225000;   // 4.5 ms leader space (full frame)
  localparam int NEC_T_REP_HI     = 112500;   // 2.25 ms leader space (repeat frame)
  localparam int NEC_T_BIT_LO     = 28000;    // 560 us bit / stop burst
  localparam int NEC_T_ZERO_HI    = 28000;    // 560 us logic-0 space
  localparam int NEC_T_ONE_HI     = 84500;    // 1690 us logic-1 space
  localparam int NEC_T_GAP        = 2000000;  // 40 ms quiet time after the stop burst
  localparam int NEC_CARRIER_HALF = 658;      // half period of the ~38 kHz carrier

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LO,
    LEAD_HI,
    BIT_LO,
    BIT_HI,
    STOP_LO,
    GAP
  } inf_state_e;

  function automatic logic is_burst(input inf_state_e s);
    return (s == LEAD_LO) || (s == BIT_LO) || (s == STOP_LO);
  endfunction

endpackage

// File: rtl/inf_carrier_gen.sv
// inf_carrier_gen: 50 % duty carrier gated by a burst enable.
//   sys_clk  in   system clock
//   sys_rst  in   synchronous active-high reset
//   en       in   burst active (for the cycle being registered)
//   carrier  out  registered carrier, 0 whenever en = 0
// The phase counter is held at 0 while en is low, so every burst starts
// with a full high half-period.
module inf_carrier_gen
  import inf_pkg::*;
#(
  parameter int CARRIER_HALF = NEC_CARRIER_HALF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  output logic carrier
);

  localparam int CNT_W = (CARRIER_HALF > 1) ? $clog2(2 * CARRIER_HALF) : 1;
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CARRIER_HALF);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * CARRIER_HALF - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !en) begin
      cnt_q   <= '0;
      carrier <= 1'b0;
    end else begin
      carrier <= (cnt_q < HALF);
      cnt_q   <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/inf_tx.sv
// inf_tx: NEC infrared transmitter.
//   sys_clk  in   system clock
//   sys_rst  in   synchronous active-high reset
//   addr     in   8-bit address, sampled on an accepted start
//   cmd      in   8-bit command, sampled on an accepted start
//   start    in   one-cycle request for a full frame
//   rpt      in   one-cycle request for a repeat frame
//   busy     out  high while a frame or its trailing gap is in progress
//   done     out  one-cycle pulse at the end of the gap
//   inf_out  out  baseband level: 0 = burst, 1 = space / idle
//   ir_led   out  inf_out bursts on the carrier, 0 during spaces
// All outputs are registered from the next-state decode, so they change on
// the same edge as the state register.
module inf_tx
  import inf_pkg::*;
#(
  parameter int T_LEAD_LO    = NEC_T_LEAD_LO,
  parameter int T_LEAD_HI    = NEC_T_LEAD_HI,
  parameter int T_REP_HI     = NEC_T_REP_HI,
  parameter int T_BIT_LO     = NEC_T_BIT_LO,
  parameter int T_ZERO_HI    = NEC_T_ZERO_HI,
  parameter int T_ONE_HI     = NEC_T_ONE_HI,
  parameter int T_GAP        = NEC_T_GAP,
  parameter int CARRIER_HALF = NEC_CARRIER_HALF
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  input  logic       start,
  input  logic       rpt,
  output logic       busy,
  output logic       done,
  output logic       inf_out,
  output logic       ir_led
);

  // Duration reload values: each phase counts down from length-1 to 0.
  localparam logic [31:0] LD_LEAD_LO = 32'(T_LEAD_LO - 1);
  localparam logic [31:0] LD_LEAD_HI = 32'(T_LEAD_HI - 1);
  localparam logic [31:0] LD_REP_HI  = 32'(T_REP_HI - 1);
  localparam logic [31:0] LD_BIT_LO  = 32'(T_BIT_LO - 1);
  localparam logic [31:0] LD_ZERO_HI = 32'(T_ZERO_HI - 1);
  localparam logic [31:0] LD_ONE_HI  = 32'(T_ONE_HI - 1);
  localparam logic [31:0] LD_GAP     = 32'(T_GAP - 1);

  inf_state_e  state_q, state_d;
  logic [31:0] dur_q, dur_ld;
  logic        dur_load;
  logic [31:0] sr_q;
  logic [4:0]  bit_cnt_q;
  logic        rpt_q;       // current frame is a repeat frame
  logic        sent_once_q; // a frame has completed since reset
  logic        accept_start, accept_rpt, do_shift, gap_end;

  // Next-state / phase-length decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d      = state_q;
    dur_load     = 1'b0;
    dur_ld       = '0;
    accept_start = 1'b0;
    accept_rpt   = 1'b0;
    do_shift     = 1'b0;
    gap_end      = 1'b0;

    if (state_q == IDLE) begin
      // start has priority; rpt only after a completed frame.
      if (start) begin
        accept_start = 1'b1;
        state_d      = LEAD_LO;
        dur_load     = 1'b1;
        dur_ld       = LD_LEAD_LO;
      end else if (rpt && sent_once_q) begin
        accept_rpt = 1'b1;
        state_d    = LEAD_LO;
        dur_load   = 1'b1;
        dur_ld     = LD_LEAD_LO;
      end
    end else if (dur_q == '0) begin
      dur_load = 1'b1;
      case (state_q)
        LEAD_LO: begin
          state_d = LEAD_HI;
          dur_ld  = rpt_q ? LD_REP_HI : LD_LEAD_HI;
        end
        LEAD_HI: begin
          state_d = rpt_q ? STOP_LO : BIT_LO;
          dur_ld  = LD_BIT_LO;
        end
        BIT_LO: begin
          state_d = BIT_HI;
          dur_ld  = sr_q[0] ? LD_ONE_HI : LD_ZERO_HI;
        end
        BIT_HI: begin
          dur_ld = LD_BIT_LO;
          if (bit_cnt_q == 5'd31) begin
            state_d = STOP_LO;
          end else begin
            state_d  = BIT_LO;
            do_shift = 1'b1;
          end
        end
        STOP_LO: begin
          state_d = GAP;
          dur_ld  = LD_GAP;
        end
        default: begin // GAP
          state_d  = IDLE;
          dur_load = 1'b0;
          gap_end  = 1'b1;
        end
      endcase
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      dur_q       <= '0;
      rpt_q       <= 1'b0;
      sent_once_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      inf_out     <= 1'b1;
    end else begin
      state_q <= state_d;
      if (dur_load) begin
        dur_q <= dur_ld;
      end else if (dur_q != '0) begin
        dur_q <= dur_q - 32'd1;
      end
      if (accept_start || accept_rpt) begin
        rpt_q <= accept_rpt;
      end
      if (gap_end) begin
        sent_once_q <= 1'b1;
      end
      busy    <= (state_d != IDLE);
      done    <= gap_end;
      inf_out <= !is_burst(state_d);
    end
  end

  // NOTE: the payload shift register and bit counter carry no reset; both are
  // loaded on every accepted start before they are ever read.
  always_ff @(posedge sys_clk) begin
    if (accept_start) begin
      sr_q      <= {~cmd, cmd, ~addr, addr};
      bit_cnt_q <= '0;
    end else if (do_shift) begin
      sr_q      <= {1'b0, sr_q[31:1]};
      bit_cnt_q <= bit_cnt_q + 5'd1;
    end
  end

  // The carrier enable follows the next state so ir_led lines up with inf_out.
  inf_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .en     (is_burst(state_d)),
    .carrier(ir_led)
  );

endmodule
